// File: rtl/uart_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, LED codes, defaults.
// UART_RX_PARITY_EN adds the PARITY state between DATA and STOP.
package uart_pkg;

    localparam int N_DEF           = 8;
    localparam int COUNT_TICKS_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } rx_state_t;

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_START = 4'b0010;
    localparam logic [3:0] LED_DATA  = 4'b0100;
    localparam logic [3:0] LED_STOP  = 4'b1000;

    // PARITY shares the DATA lamp so the LED word stays one-hot over four bits.
    function automatic logic [3:0] state_led(input rx_state_t st);
        logic [3:0] led;
        led = LED_IDLE;
        case (st)
            IDLE:    led = LED_IDLE;
            START:   led = LED_START;
            DATA:    led = LED_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  led = LED_DATA;
`endif
            STOP:    led = LED_STOP;
            default: led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an idle-high asynchronous line.
// Latency: 2 clocks. No backpressure; output powers up and resets to 1.
module rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 receiver: line -> parallel bytes using a shared 16x baud tick.
// Latency: o_valid one clock after the mid-stop-bit tick. No backpressure: pulses must be taken when seen.
// Build option UART_RX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int COUNT_TICKS = COUNT_TICKS_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_rx,
    output logic [N-1:0] o_data,
    output logic         o_valid,
    output logic         o_frame_err,
    output logic         o_parity_err,
    output logic [3:0]   o_state,
    output logic         o_started
);

    localparam int SW = $clog2(COUNT_TICKS);
    localparam int NW = $clog2(N + 1);
    localparam logic [SW-1:0] S_MID  = SW'(COUNT_TICKS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(COUNT_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);

    rx_state_t     state;
    logic [SW-1:0] s;
    logic [NW-1:0] n;
    logic [N-1:0]  shreg;
    logic          rx_s;
    logic          parity_ok;

    rx_sync u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_rx),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_err_q;
    assign parity_ok    = ~(^shreg ^ par_bit);
    assign o_parity_err = par_err_q;
`else
    assign parity_ok    = 1'b1;
    assign o_parity_err = 1'b0;
`endif

    assign o_state = state_led(state);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_started   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (s == S_MID) begin
                            // A line that is high again at mid start bit was noise.
                            if (!rx_s) begin
                                state     <= DATA;
                                s         <= '0;
                                n         <= '0;
                                o_started <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[N-1:1]};
                            n     <= n + 1'b1;
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s       <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (i_tick) begin
                        if (s == S_LAST) begin
                            s         <= '0;
                            state     <= IDLE;
                            o_started <= 1'b0;
                            if (rx_s) begin
                                if (parity_ok) begin
                                    o_data  <= shreg;
                                    o_valid <= 1'b1;
                                end
                            end else begin
                                o_frame_err <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            par_err_q <= ~parity_ok;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames plus random traffic against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

    localparam int TICK_DIV = 5;
    localparam int CT       = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_parity_err, o_started;
    logic [3:0] o_state;

    always #25 i_clk = ~i_clk;

    uart_rx_sampler dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_state      (o_state),
        .o_started    (o_started)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic       valid;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;
    logic       started_seen = 1'b0;
    logic [3:0] st_prev = 4'b0001;
    logic [3:0] st_log[$];
    logic       rec_en = 1'b0;

    initial begin : tick_gen
        int tc;
        tc = 0;
        forever begin
            @(negedge i_clk);
            tc = (tc + 1) % TICK_DIV;
            i_tick = (tc == 0);
        end
    end

    // Each output pulse must match the oldest outstanding frame outcome.
    always @(negedge i_clk) begin
        if (!i_rst && (o_valid || o_frame_err || o_parity_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, o_valid, o_frame_err, o_parity_err}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("valid", o_valid, mon_e.valid);
                chk("frame_err", o_frame_err, mon_e.ferr);
                chk("parity_err", o_parity_err, mon_e.perr);
                chk("data", o_data, mon_e.data);
                chk("started_clear", o_started, 0);
            end
        end
        if (o_started) started_seen = 1'b1;
        if (rec_en && o_state !== st_prev) begin
            st_log.push_back(o_state);
            st_prev = o_state;
        end
    end

    task automatic wait_ticks(input int k);
        repeat (k) begin
            @(posedge i_clk);
            while (!i_tick) @(posedge i_clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop, input bit bad_par);
        ev_t e;
        bit  perr;
`ifdef UART_RX_PARITY_EN
        perr = bad_par;
`else
        perr = 1'b0;
`endif
        e.valid = !bad_stop && !perr;
        e.ferr  = bad_stop;
        e.perr  = perr;
        if (e.valid) last_good = d;
        e.data  = last_good;
        exp_q.push_back(e);
        i_rx = 1'b0;
        wait_ticks(CT);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_ticks(CT);
            if (i == 3) begin
                @(negedge i_clk);
                chk("started_mid_frame", o_started, 1);
                chk("state_data_led", o_state, 4'b0100);
            end
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^d) ^ bad_par;
        wait_ticks(CT);
`endif
        if (bad_stop) begin
            i_rx = 1'b0;
            wait_ticks(10);
            i_rx = 1'b1;
            wait_ticks(CT - 10);
        end else begin
            i_rx = 1'b1;
            wait_ticks(CT);
        end
    endtask

    task automatic send_glitch(input int g);
        started_seen = 1'b0;
        i_rx = 1'b0;
        wait_ticks(g);
        i_rx = 1'b1;
        wait_ticks(12);
        chk("glitch_no_start", started_seen, 0);
        chk("glitch_idle", o_state, 4'b0001);
    endtask

    initial begin
        logic [3:0] exp_seq[4];
        logic [7:0] partial;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        partial = 8'h3C;

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_perr", o_parity_err, 0);
        chk("rst_state", o_state, 4'b0001);
        chk("rst_started", o_started, 0);
        i_rst = 1'b0;
        wait_ticks(20);

        st_prev = 4'b0001;
        st_log.delete();
        rec_en = 1'b1;
        send_frame(8'h08, 1'b0, 1'b0);
        wait_ticks(4);
        rec_en = 1'b0;
        chk("state_seq_len", st_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < st_log.size()) chk("state_seq", st_log[i], exp_seq[i]);

        send_frame(8'h07, 1'b0, 1'b0);
        send_frame(8'd11, 1'b0, 1'b0);
        send_frame(8'h0D, 1'b0, 1'b0);
        wait_ticks(8);

        send_glitch(4);

        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(2 * CT);
        chk("hold_after_ferr", o_data, 8'h0D);

        i_rx = 1'b0;
        wait_ticks(CT);
        for (int i = 0; i < 3; i++) begin
            i_rx = partial[i];
            wait_ticks(CT);
        end
        wait_ticks(5);
        #7;
        i_rst = 1'b1;
        #1;
        chk("midrst_data", o_data, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ferr", o_frame_err, 0);
        chk("midrst_state", o_state, 4'b0001);
        chk("midrst_started", o_started, 0);
        last_good = 8'h00;
        i_rx = 1'b1;
        repeat (3) @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        wait_ticks(20);
        send_frame(8'h52, 1'b0, 1'b0);
        wait_ticks(4);
        chk("after_rst_data", o_data, 8'h52);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h01, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0)
                send_glitch(int'($urandom_range(1, 6)));
            else
                send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            i_rx = 1'b1;
            wait_ticks(int'($urandom_range(0, 2)) * CT);
        end

        wait_ticks(40);
        chk("pending_expect", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
